// File: rtl/gen3_pkt_pkg.sv
// Shared token constants, byte type codes and framing state for the Gen3
// packet identifier.
package gen3_pkt_pkg;

  localparam logic [3:0] STP_NIBBLE = 4'hF;
  localparam logic [7:0] SDP_BYTE0  = 8'hF0;
  localparam logic [7:0] SDP_BYTE1  = 8'h53;
  localparam logic [7:0] EDB_BYTE   = 8'hC0;

  typedef logic [5:0] ptype_t;

  localparam ptype_t TYPE_NOT_VALID = 6'b000000;
  localparam ptype_t TYPE_DATA      = 6'b100000;
  localparam ptype_t TYPE_TLPSTART  = 6'b010000;
  localparam ptype_t TYPE_TLPEND    = 6'b001000;
  localparam ptype_t TYPE_DLLPEND   = 6'b000100;
  localparam ptype_t TYPE_DLLPSTART = 6'b000010;
  localparam ptype_t TYPE_TLPEDB    = 6'b000001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SDP1,
    S_DLLP,
    S_STP1,
    S_TLP,
    S_EDB
  } state_e;

  typedef struct packed {
    state_e      state;
    logic [10:0] len;
    logic [12:0] cnt;
    logic [12:0] limit;
    logic [2:0]  edb_cnt;
    logic        prev_tlp;
  } bundle_t;

  localparam bundle_t BUNDLE_RESET = '{
    state:    S_IDLE,
    len:      11'd0,
    cnt:      13'd0,
    limit:    13'd0,
    edb_cnt:  3'd0,
    prev_tlp: 1'b0
  };

endpackage

// File: rtl/gen3_byte_step.sv
// Combinational framing step for one byte: classifies the byte and computes
// the framing state seen by the next byte in stream order.
module gen3_byte_step
  import gen3_pkt_pkg::*;
#(
  parameter int DLLP_BYTES = 6,
  parameter int LEN_MIN    = 5
) (
  input  logic [7:0] data,
  input  bundle_t    cur,
  output ptype_t     ptype,
  output logic       err,
  output bundle_t    nxt
);

  ptype_t      idle_type;
  bundle_t     idle_nxt;
  logic [10:0] stp_len;
  logic [12:0] cnt_inc;
  logic [2:0]  edb_inc;

  assign stp_len = {data[6:0], cur.len[3:0]};
  assign cnt_inc = cur.cnt + 13'd1;
  assign edb_inc = cur.edb_cnt + 3'd1;

  // IDLE interpretation of the byte; also reused when an F0 is not followed by 53.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    idle_nxt          = cur;
    idle_nxt.state    = S_IDLE;
    idle_nxt.prev_tlp = 1'b0;
    idle_type         = TYPE_NOT_VALID;
    if (data[3:0] == STP_NIBBLE) begin
      idle_type         = TYPE_TLPSTART;
      idle_nxt.len[3:0] = data[7:4];
      idle_nxt.state    = S_STP1;
    end else if (data == SDP_BYTE0) begin
      idle_nxt.state = S_SDP1;
    end else if (data == EDB_BYTE && cur.prev_tlp) begin
      idle_type        = TYPE_TLPEDB;
      idle_nxt.edb_cnt = 3'd1;
      idle_nxt.state   = S_EDB;
    end
  end

  always_comb begin
    nxt   = cur;
    ptype = TYPE_NOT_VALID;
    err   = 1'b0;
    unique case (cur.state)
      S_IDLE: begin
        nxt   = idle_nxt;
        ptype = idle_type;
      end
      S_SDP1: begin
        if (data == SDP_BYTE1) begin
          ptype     = TYPE_DLLPSTART;
          nxt.cnt   = 13'd0;
          nxt.state = S_DLLP;
        end else begin
          nxt   = idle_nxt;
          ptype = idle_type;
        end
      end
      S_DLLP: begin
        nxt.cnt = cnt_inc;
        if (cnt_inc == 13'(DLLP_BYTES)) begin
          ptype     = TYPE_DLLPEND;
          nxt.state = S_IDLE;
        end else begin
          ptype = TYPE_DATA;
        end
      end
      S_STP1: begin
        nxt.len = stp_len;
        if (stp_len < 11'(LEN_MIN)) begin
          err       = 1'b1;
          nxt.state = S_IDLE;
        end else begin
          ptype     = TYPE_DATA;
          nxt.limit = {stp_len, 2'b00};
          nxt.cnt   = 13'd2;
          nxt.state = S_TLP;
        end
      end
      // cnt counts bytes already consumed, so this byte is number cnt+1.
      S_TLP: begin
        nxt.cnt = cnt_inc;
        if (cnt_inc == cur.limit) begin
          ptype        = TYPE_TLPEND;
          nxt.prev_tlp = 1'b1;
          nxt.state    = S_IDLE;
        end else begin
          ptype = TYPE_DATA;
        end
      end
      S_EDB: begin
        if (data == EDB_BYTE) begin
          ptype       = TYPE_TLPEDB;
          nxt.edb_cnt = edb_inc;
          if (edb_inc == 3'd4) nxt.state = S_IDLE;
        end else begin
          err       = 1'b1;
          nxt.state = S_IDLE;
        end
      end
      default: nxt = BUNDLE_RESET;
    endcase
  end

endmodule

// File: rtl/gen3_packet_identifier.sv
// Multi-lane Gen3 packet identifier: chains one byte step per lane and
// registers the framing state and per-byte classification each beat.
module gen3_packet_identifier
  import gen3_pkt_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int DLLP_BYTES = 6,
  parameter int LEN_MIN    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  input  logic [8*LANES-1:0] data_in,
  output logic               valid_out,
  output logic [6*LANES-1:0] type_out,
  output logic               malformed
);

  bundle_t            state_q;
  bundle_t            chain [LANES+1];
  logic [6*LANES-1:0] type_w;
  logic [LANES-1:0]   err_w;

  assign chain[0] = state_q;

  // Lane 0 is earliest in stream order, so state ripples upward through the lanes.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    gen3_byte_step #(
      .DLLP_BYTES(DLLP_BYTES),
      .LEN_MIN   (LEN_MIN)
    ) u_step (
      .data (data_in[8*i +: 8]),
      .cur  (chain[i]),
      .ptype(type_w[6*i +: 6]),
      .err  (err_w[i]),
      .nxt  (chain[i+1])
    );
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q   <= BUNDLE_RESET;
      valid_out <= 1'b0;
      type_out  <= '0;
      malformed <= 1'b0;
    end else if (valid_in) begin
      state_q   <= chain[LANES];
      valid_out <= 1'b1;
      type_out  <= type_w;
      malformed <= |err_w;
    end else begin
      valid_out <= 1'b0;
      type_out  <= '0;
      malformed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gen3_packet_identifier.sv
// Directed-vector bench for gen3_packet_identifier with LANES=4.
module tb_gen3_packet_identifier;

  localparam logic [5:0] NV = 6'b000000;
  localparam logic [5:0] DA = 6'b100000;
  localparam logic [5:0] TS = 6'b010000;
  localparam logic [5:0] TE = 6'b001000;
  localparam logic [5:0] DE = 6'b000100;
  localparam logic [5:0] DS = 6'b000010;
  localparam logic [5:0] EB = 6'b000001;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] data_in;
  logic        valid_out;
  logic [23:0] type_out;
  logic        malformed;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gen3_packet_identifier #(
    .LANES     (4),
    .DLLP_BYTES(6),
    .LEN_MIN   (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .data_in  (data_in),
    .valid_out(valid_out),
    .type_out (type_out),
    .malformed(malformed)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic beat(input string tag,
                      input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [7:0] b3,
                      input logic [5:0] t0, input logic [5:0] t1,
                      input logic [5:0] t2, input logic [5:0] t3,
                      input logic mal);
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = {b3, b2, b1, b0};
    @(posedge clk);
    #1;
    check({tag, " type"}, 32'(type_out), 32'({t3, t2, t1, t0}));
    check({tag, " malformed"}, 32'(malformed), 32'(mal));
    check({tag, " valid"}, 32'(valid_out), 32'd1);
  endtask

  task automatic data_beats(input string tag, input int n);
    for (int i = 0; i < n; i++)
      beat(tag, 8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3), DA, DA, DA, DA, 1'b0);
  endtask

  task automatic gap(input string tag);
    @(negedge clk);
    valid_in = 1'b0;
    data_in  = 32'hC0F0_535F;
    @(posedge clk);
    #1;
    check({tag, " type"}, 32'(type_out), 32'd0);
    check({tag, " malformed"}, 32'(malformed), 32'd0);
    check({tag, " valid"}, 32'(valid_out), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset type", 32'(type_out), 32'd0);
    check("reset malformed", 32'(malformed), 32'd0);
    check("reset valid", 32'(valid_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // DLLP spanning three beats
    beat("dllp b1", 8'h00, 8'h00, 8'hF0, 8'h53, NV, NV, NV, DS, 1'b0);
    beat("dllp b2", 8'h11, 8'h22, 8'h33, 8'h44, DA, DA, DA, DA, 1'b0);
    beat("dllp b3", 8'h55, 8'h66, 8'h00, 8'h00, DA, DE, NV, NV, 1'b0);

    // minimal 20-byte TLP followed by a full EDB
    beat("tlp b1", 8'h5F, 8'h00, 8'h01, 8'h02, TS, DA, DA, DA, 1'b0);
    data_beats("tlp mid", 3);
    beat("tlp end", 8'h10, 8'h11, 8'h12, 8'h13, DA, DA, DA, TE, 1'b0);
    beat("edb x4", 8'hC0, 8'hC0, 8'hC0, 8'hC0, EB, EB, EB, EB, 1'b0);

    // truncated EDB after a TLP
    beat("tlp2 b1", 8'h5F, 8'h00, 8'h01, 8'h02, TS, DA, DA, DA, 1'b0);
    data_beats("tlp2 mid", 3);
    beat("tlp2 end", 8'h10, 8'h11, 8'h12, 8'h13, DA, DA, DA, TE, 1'b0);
    beat("edb short", 8'hC0, 8'hC0, 8'h00, 8'h00, EB, EB, NV, NV, 1'b1);
    beat("after edb err", 8'h00, 8'h00, 8'h00, 8'h00, NV, NV, NV, NV, 1'b0);

    // short length, then a TLP ending in lane 1 with an SDP behind it
    beat("short len", 8'h3F, 8'h00, 8'h5F, 8'h00, TS, NV, TS, DA, 1'b1);
    data_beats("tlp3 mid", 4);
    beat("tlpend+sdp", 8'hAA, 8'hBB, 8'hF0, 8'h53, DA, TE, NV, DS, 1'b0);

    // DLLP body, then a false SDP whose second byte starts a TLP
    beat("dllp2 b1", 8'h01, 8'h02, 8'h03, 8'h04, DA, DA, DA, DA, 1'b0);
    beat("false sdp", 8'h05, 8'h06, 8'hF0, 8'h5F, DA, DE, NV, TS, 1'b0);

    // idle gaps inside a TLP must not disturb the byte count
    beat("tlp4 b1", 8'h00, 8'h01, 8'h02, 8'h03, DA, DA, DA, DA, 1'b0);
    gap("gap1");
    gap("gap2");
    data_beats("tlp4 mid", 3);
    beat("tlp4 end", 8'hAA, 8'hBB, 8'hCC, 8'h00, DA, DA, TE, NV, 1'b0);

    // reset mid-TLP wins over valid_in; packet is dropped silently
    beat("tlp5 b1", 8'h5F, 8'h00, 8'h01, 8'h02, TS, DA, DA, DA, 1'b0);
    @(negedge clk);
    rst      = 1'b1;
    valid_in = 1'b1;
    data_in  = 32'h0706_0504;
    @(posedge clk);
    #1;
    check("rst mid type", 32'(type_out), 32'd0);
    check("rst mid malformed", 32'(malformed), 32'd0);
    check("rst mid valid", 32'(valid_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    beat("post rst b1", 8'hF0, 8'h53, 8'h01, 8'h02, NV, DS, DA, DA, 1'b0);
    beat("post rst b2", 8'h03, 8'h04, 8'h05, 8'h06, DA, DA, DA, DE, 1'b0);
    beat("c0 no tlp", 8'hC0, 8'h00, 8'h00, 8'h00, NV, NV, NV, NV, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
